// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the pixel-layer requesters, the shared sprite ROM and the
// response consumer. The arbiter sits on the slave side; address generators,
// the ROM model and the colour mapper sit on the master side.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_rdata;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req, req_addr, rom_rdata,
        input  gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, req_addr, rom_rdata,
        output gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/palette ROM port among
// several pixel layers. One grant per cycle, combinational grant, ROM data
// returned tagged with the requester id ROM_LAT+1 cycles after the grant.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);
    typedef logic [ID_W-1:0] id_t;

    id_t  rr_ptr;
    id_t  win_id;
    logic win_vld;
    int   idx;

    // In-flight ROM reads: valid travels with the requester id
    logic vld_p [ROM_LAT];
    id_t  id_p  [ROM_LAT];

    // Scan requesters starting at rr_ptr (wrapping); first asserted one wins.
    // Reset gates every grant so nothing reaches the ROM while held in reset.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (Reset_n && !win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = id_t'(idx);
            end
        end
    end

    // One-hot grant and ROM address mux; address is zero when idle.
    always_comb begin
        bus.gnt      = '0;
        bus.rom_addr = '0;
        if (win_vld) begin
            bus.gnt[win_id] = 1'b1;
            bus.rom_addr    = bus.req_addr[win_id*ADDR_W +: ADDR_W];
        end
    end

    assign bus.rom_en = win_vld;

    // Pointer moves past the winner; frame_start re-seeds it to requester 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= '0;
        end else if (frame_start) begin
            rr_ptr <= '0;
        end else if (win_vld) begin
            rr_ptr <= (win_id == id_t'(N_REQ - 1)) ? id_t'(0) : id_t'(win_id + 1'b1);
        end
    end

    // Valid bits of the in-flight pipeline; reset drops outstanding reads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                vld_p[s] <= 1'b0;
            end
        end else begin
            vld_p[0] <= win_vld;
            for (int s = 1; s < ROM_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Requester ids ride alongside the valid bits; only meaningful when valid.
    always_ff @(posedge Clk) begin
        id_p[0] <= win_id;
        for (int s = 1; s < ROM_LAT; s++) begin
            id_p[s] <= id_p[s-1];
        end
    end

    // Response register: capture ROM data at the last stage, hold otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= vld_p[ROM_LAT-1];
            if (vld_p[ROM_LAT-1]) begin
                bus.rsp_id   <= id_p[ROM_LAT-1];
                bus.rsp_data <= bus.rom_rdata;
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT=1 and ROM_LAT=2) share
// stimulus; each has its own ROM model and is checked every cycle against a
// queue/slot based model, plus directed literal expectations.
module tb_sprite_rom_arbiter;
    logic        Clk;
    logic        Reset_n;
    logic        frame_start;
    logic [3:0]  req;
    logic [17:0] addr [4];
    logic [17:0] r1a, r2a, r2b;

    int n_chk;
    int n_err;
    int cyc;

    int ptr      [2];
    bit slot_v   [2][8];
    int slot_id  [2][8];
    int slot_dat [2][8];
    int last_id  [2];
    int last_dat [2];
    int lat      [2];

    sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(18), .DATA_W(4)) if1 ();
    sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(18), .DATA_W(4)) if2 ();

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(18), .DATA_W(4), .ROM_LAT(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .bus(if1.slave));
    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(18), .DATA_W(4), .ROM_LAT(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .bus(if2.slave));

    // ROM contents: sum of address nibbles plus one, modulo 16
    function automatic int romf(input logic [17:0] a);
        return (int'(a[3:0]) + int'(a[7:4]) + int'(a[11:8]) + int'(a[15:12])
                + int'(a[17:16]) + 1) % 16;
    endfunction

    assign if1.req       = req;
    assign if2.req       = req;
    assign if1.req_addr  = {addr[3], addr[2], addr[1], addr[0]};
    assign if2.req_addr  = {addr[3], addr[2], addr[1], addr[0]};
    assign if1.rom_rdata = 4'(romf(r1a));
    assign if2.rom_rdata = 4'(romf(r2b));

    // Synchronous ROM models, latency 1 and 2
    always @(posedge Clk) begin
        r1a <= if1.rom_addr;
        r2a <= if2.rom_addr;
        r2b <= r2a;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model for one instance: plain round-robin scan over the
    // request vector, responses scheduled into a ring of future cycles.
    task automatic model_inst(input int k);
        logic [3:0]  g;
        logic        en;
        logic [17:0] ra;
        logic        v;
        logic [1:0]  id;
        logic [3:0]  d;
        int w, i, s, due;
        string p;
        p = $sformatf("L%0d ", lat[k]);
        if (k == 0) begin
            g = if1.gnt; en = if1.rom_en; ra = if1.rom_addr;
            v = if1.rsp_valid; id = if1.rsp_id; d = if1.rsp_data;
        end else begin
            g = if2.gnt; en = if2.rom_en; ra = if2.rom_addr;
            v = if2.rsp_valid; id = if2.rsp_id; d = if2.rsp_data;
        end
        if (!Reset_n) begin
            chk({p, "gnt in reset"}, int'(g), 0);
            chk({p, "rom_en in reset"}, int'(en), 0);
            chk({p, "rom_addr in reset"}, int'(ra), 0);
            chk({p, "rsp_valid in reset"}, int'(v), 0);
            chk({p, "rsp_id in reset"}, int'(id), 0);
            chk({p, "rsp_data in reset"}, int'(d), 0);
            ptr[k] = 0;
            for (int j = 0; j < 8; j++) slot_v[k][j] = 1'b0;
            last_id[k]  = 0;
            last_dat[k] = 0;
        end else begin
            w = -1;
            for (int j = 0; j < 4; j++) begin
                i = (ptr[k] + j) % 4;
                if (w < 0 && req[i]) w = i;
            end
            chk({p, "gnt"}, int'(g), (w < 0) ? 0 : (1 << w));
            chk({p, "rom_en"}, int'(en), (w < 0) ? 0 : 1);
            chk({p, "rom_addr"}, int'(ra), (w < 0) ? 0 : int'(addr[w]));
            s = cyc % 8;
            if (slot_v[k][s]) begin
                chk({p, "rsp_valid"}, int'(v), 1);
                chk({p, "rsp_id"}, int'(id), slot_id[k][s]);
                chk({p, "rsp_data"}, int'(d), slot_dat[k][s]);
                last_id[k]  = slot_id[k][s];
                last_dat[k] = slot_dat[k][s];
                slot_v[k][s] = 1'b0;
            end else begin
                chk({p, "rsp_valid idle"}, int'(v), 0);
                chk({p, "rsp_id hold"}, int'(id), last_id[k]);
                chk({p, "rsp_data hold"}, int'(d), last_dat[k]);
            end
            if (w >= 0) begin
                due = (cyc + lat[k] + 1) % 8;
                slot_v[k][due]   = 1'b1;
                slot_id[k][due]  = w;
                slot_dat[k][due] = romf(addr[w]);
            end
            if (frame_start)  ptr[k] = 0;
            else if (w >= 0)  ptr[k] = (w + 1) % 4;
        end
    endtask

    // Apply one cycle of inputs after the edge, then check at the falling edge
    task automatic step(input logic [3:0] r, input logic fs, input logic rn);
        @(posedge Clk);
        #1;
        req         = r;
        frame_start = fs;
        Reset_n     = rn;
        @(negedge Clk);
        model_inst(0);
        model_inst(1);
        cyc++;
    endtask

    int rr_exp [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    int sk_exp [3] = '{8, 1, 8};

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        lat[0] = 1; lat[1] = 2;
        addr[0] = 18'h3A5C1; addr[1] = 18'h01F2E;
        addr[2] = 18'h00123; addr[3] = 18'h2BEEF;
        Reset_n = 1'b0; req = 4'b0000; frame_start = 1'b0;

        // Reset held with all requesting
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        chk("reset gnt", int'(if1.gnt), 0);
        chk("reset rom_en", int'(if1.rom_en), 0);
        chk("reset rsp_valid", int'(if1.rsp_valid), 0);
        chk("reset rsp_id", int'(if1.rsp_id), 0);
        chk("reset rsp_data", int'(if1.rsp_data), 0);

        // Round-robin with all requesting; first cycle after release grants 0
        for (int j = 0; j < 8; j++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk("rr gnt L1", int'(if1.gnt), rr_exp[j]);
            chk("rr gnt L2", int'(if2.gnt), rr_exp[j]);
            if (j >= 2) chk("rr rsp_id L1", int'(if1.rsp_id), (j - 2) % 4);
            if (j >= 3) chk("rr rsp_valid L2", int'(if2.rsp_valid), 1);
        end
        for (int j = 0; j < 3; j++) step(4'b0000, 1'b0, 1'b1);

        // Skip idle requesters: move pointer to 1, then only 0 and 3 request
        step(4'b0001, 1'b0, 1'b1);
        chk("skip setup gnt", int'(if1.gnt), 1);
        for (int j = 0; j < 3; j++) begin
            step(4'b1001, 1'b0, 1'b1);
            chk("skip gnt", int'(if1.gnt), sk_exp[j]);
        end
        for (int j = 0; j < 3; j++) step(4'b0000, 1'b0, 1'b1);

        // Single requester 2 at address 0x00123, ROM returns 7
        step(4'b0100, 1'b0, 1'b1);
        chk("single gnt", int'(if1.gnt), 4);
        chk("single rom_addr", int'(if1.rom_addr), 18'h00123);
        step(4'b0000, 1'b0, 1'b1);
        chk("single early rsp_valid L1", int'(if1.rsp_valid), 0);
        step(4'b0000, 1'b0, 1'b1);
        chk("single rsp_valid L1", int'(if1.rsp_valid), 1);
        chk("single rsp_id L1", int'(if1.rsp_id), 2);
        chk("single rsp_data L1", int'(if1.rsp_data), 7);
        step(4'b0000, 1'b0, 1'b1);
        chk("single rsp_valid drop L1", int'(if1.rsp_valid), 0);
        chk("single rsp_valid L2", int'(if2.rsp_valid), 1);
        chk("single rsp_data L2", int'(if2.rsp_data), 7);

        // frame_start: grant 1 (pointer -> 2), then pulse with 1 and 2 requesting
        step(4'b0010, 1'b0, 1'b1);
        chk("fs first gnt", int'(if1.gnt), 2);
        step(4'b0110, 1'b1, 1'b1);
        chk("fs same-cycle gnt", int'(if1.gnt), 4);
        step(4'b0110, 1'b0, 1'b1);
        chk("fs reseeded gnt", int'(if1.gnt), 2);
        chk("fs inflight rsp_valid L1", int'(if1.rsp_valid), 1);
        chk("fs inflight rsp_id L1", int'(if1.rsp_id), 1);
        step(4'b0110, 1'b0, 1'b1);
        chk("fs next gnt", int'(if1.gnt), 4);
        for (int j = 0; j < 3; j++) step(4'b0000, 1'b0, 1'b1);

        // Reset mid-operation: two grants, then reset drops everything in flight
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("midrst gnt L2", int'(if2.gnt), 0);
        chk("midrst rsp_valid L2", int'(if2.rsp_valid), 0);
        chk("midrst rsp_valid L1", int'(if1.rsp_valid), 0);
        for (int j = 0; j < 4; j++) begin
            step(4'b0000, 1'b0, 1'b1);
            chk("post-reset rsp_valid L2", int'(if2.rsp_valid), 0);
        end

        // Normal ROM_LAT=2 path: response exactly three cycles after grant
        step(4'b0010, 1'b0, 1'b1);
        chk("lat2 gnt", int'(if2.gnt), 2);
        step(4'b0000, 1'b0, 1'b1);
        chk("lat2 +1 rsp_valid", int'(if2.rsp_valid), 0);
        step(4'b0000, 1'b0, 1'b1);
        chk("lat2 +2 rsp_valid", int'(if2.rsp_valid), 0);
        step(4'b0000, 1'b0, 1'b1);
        chk("lat2 +3 rsp_valid", int'(if2.rsp_valid), 1);
        chk("lat2 +3 rsp_id", int'(if2.rsp_id), 1);
        chk("lat2 +3 rsp_data", int'(if2.rsp_data), 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("lat2 +4 rsp_valid", int'(if2.rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares a single synchronous sprite/palette-index ROM port among several pixel-layer requesters (map, pellets, Pac-Man, ghosts, scoreboard) so the layers no longer each need a private ROM copy. Sits between the per-layer address generators and the color mapper. Each cycle it grants at most one request using round-robin, drives the ROM address, and returns the ROM data tagged with the requester ID after a fixed latency.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 18, ROM address width (covers 134664-entry map image)
- DATA_W, 4, ROM data width (palette index)
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of frame; re-seeds round-robin pointer
- req  in  N_REQ  request valid per requester; held with address until granted
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational; transfer when req[i] & gnt[i]
- rom_en  out  1  ROM read enable, high in any grant cycle
- rom_addr  out  ADDR_W  address of granted requester; 0 when no grant
- rom_rdata  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_en
- rsp_valid  out  1  registered response strobe
- rsp_id  out  clog2(N_REQ)  requester index of the response
- rsp_data  out  DATA_W  ROM data for that requester

## Operation
- State: rr_ptr (clog2(N_REQ) bits), in-flight pipeline of ROM_LAT stages each holding {valid, id}, response registers {rsp_valid, rsp_id, rsp_data}.
- Arbitration: winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... wrapping mod N_REQ. gnt one-hot to winner; all-zero if no req. At most one grant per cycle.
- rom_en = |gnt; rom_addr = req_addr slice of winner.
- Pointer update on edge: frame_start=1 -> rr_ptr <= 0 (overrides everything); else if grant to i -> rr_ptr <= (i+1) mod N_REQ; else hold.
- frame_start does not suppress the same-cycle grant (arbitration uses the pre-update rr_ptr) and does not flush in-flight responses.
- Pipeline stage 0 captures {rom_en, winner id}; stages shift each cycle. At the last stage, if valid: rsp_valid <= 1, rsp_id <= id, rsp_data <= rom_rdata; else rsp_valid <= 0, rsp_id/rsp_data hold.
- No response backpressure: consumers must accept rsp_* in the cycle rsp_valid is high.
- Fairness: a requester holding req continuously is granted within N_REQ cycles.
- Requesters with req=0 are skipped with no penalty; rr_ptr pointing at an idle requester is valid.
- Reset (Reset_n=0, asynchronous): rr_ptr=0, all pipeline valids=0, rsp_valid=0, rsp_id=0, rsp_data=0. gnt, rom_en forced 0 while Reset_n=0. Reset mid-transfer drops all in-flight responses; no rsp_valid for them after release.

## Timing
- Grant: same cycle as req (combinational from req, rr_ptr, Reset_n).
- Response: grant in cycle t -> rsp_valid high in cycle t+ROM_LAT+1 for exactly one cycle (per grant).
- Throughput: one grant and one response per cycle sustained; back-to-back grants yield back-to-back rsp_valid in grant order.
- rr_ptr change visible to arbitration the cycle after the update edge.
- Reset release: first grant possible in the first cycle with Reset_n=1.

## Test plan
- Reset values: hold Reset_n=0 with req=4'b1111 -> gnt=0, rom_en=0, rsp_valid=0, rsp_id=0, rsp_data=0; release -> gnt=4'b0001 first cycle.
- Single requester: req=4'b0100, addr2=18'h00123, ROM_LAT=1, ROM returns 4'h7 -> gnt=4'b0100 same cycle, rom_addr=18'h00123, rsp_valid/rsp_id=2/rsp_data=7 two cycles later, one cycle wide.
- Round-robin: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical, contiguous rsp_valid.
- Skip idle: rr_ptr=1, req=4'b1001 -> grant 3, then 0, then 3; never 1 or 2.
- frame_start: after grant to 1 (rr_ptr=2), pulse frame_start with req=4'b0110 -> that cycle grants 2, next cycle rr_ptr=0 so grant 1 before 2; in-flight response for first grant still delivered.
- Reset mid-operation with ROM_LAT=2: grants in two consecutive cycles, assert Reset_n=0 one cycle later -> rsp_valid immediately 0, no responses after release; repeat with ROM_LAT=2 normal path -> rsp_valid exactly 3 cycles after each grant.
